control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 85 ++++++++
 rtl/control_unit.sv | 158 +++++++++++++++
 tb/tb_control_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// cpu_types_pkg + control_unit_if: decode encodings and the control unit's connection bundle.
// Latency: no logic of its own; it only carries signals.
// Backpressure: none; the decoder reads opcode/funct every cycle.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        J     = 6'b000010,
        JAL   = 6'b000011,
        BEQ   = 6'b000100,
        BNE   = 6'b000101,
        ADDI  = 6'b001000,
        ADDIU = 6'b001001,
        SLTI  = 6'b001010,
        SLTIU = 6'b001011,
        ANDI  = 6'b001100,
        ORI   = 6'b001101,
        XORI  = 6'b001110,
        LUI   = 6'b001111,
        LW    = 6'b100011,
        SW    = 6'b101011,
        HALT  = 6'b111111
    } opcode_t;

    typedef enum logic [5:0] {
        SLL  = 6'b000000,
        SRL  = 6'b000010,
        JR   = 6'b001000,
        ADD  = 6'b100000,
        ADDU = 6'b100001,
        SUB  = 6'b100010,
        SUBU = 6'b100011,
        AND  = 6'b100100,
        OR   = 6'b100101,
        XOR  = 6'b100110,
        NOR  = 6'b100111,
        SLT  = 6'b101010,
        SLTU = 6'b101011
    } funct_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

endpackage

interface control_unit_if (
    input logic CLK,
    input logic RST
);
    import cpu_types_pkg::*;

    opcode_t    opcode;
    funct_t     funct;
    aluop_t     aluop;
    logic [1:0] RegDst;
    logic [1:0] ALUSrc;
    logic [1:0] MemtoReg;
    logic       RegWr;
    logic       dREN;
    logic       dWEN;
    logic       ExtOp;
    logic       Branch;
    logic       BranchNE;
    logic       Jump;
    logic       JumpReg;
    logic       halt;
    logic       illegal;

    modport cu (
        input  CLK, RST, opcode, funct,
        output aluop, RegDst, ALUSrc, MemtoReg, RegWr, dREN, dWEN, ExtOp,
               Branch, BranchNE, Jump, JumpReg, halt, illegal
    );

endinterface

// File: rtl/control_unit.sv
// control_unit: single-cycle main decoder for opcode/funct plus a sticky halt flag.
// Latency: all decode outputs are combinational (0 cycles); halt updates on the CLK edge.
// Backpressure: none; outputs track opcode/funct continuously, RST only clears halt.
module control_unit
    import cpu_types_pkg::*;
(
    control_unit_if.cu cuif
);

    aluop_t     aluop;
    logic [1:0] reg_dst;
    logic [1:0] alu_src;
    logic [1:0] mem_to_reg;
    logic       reg_wr;
    logic       d_ren;
    logic       d_wen;
    logic       ext_op;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       jump_reg;
    logic       illegal;
    logic       halt_d;
    logic       halt_q;

    // Instruction decode: everything idle with ALU_ADD, then per-opcode overrides.
    always_comb begin
        aluop      = ALU_ADD;
        reg_dst    = 2'd0;
        alu_src    = 2'd0;
        mem_to_reg = 2'd0;
        reg_wr     = 1'b0;
        d_ren      = 1'b0;
        d_wen      = 1'b0;
        ext_op     = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        jump       = 1'b0;
        jump_reg   = 1'b0;
        illegal    = 1'b0;
        case (cuif.opcode)
            RTYPE: begin
                reg_dst = 2'd1;
                reg_wr  = 1'b1;
                case (cuif.funct)
                    ADD, ADDU: aluop = ALU_ADD;
                    SUB, SUBU: aluop = ALU_SUB;
                    AND:       aluop = ALU_AND;
                    OR:        aluop = ALU_OR;
                    XOR:       aluop = ALU_XOR;
                    NOR:       aluop = ALU_NOR;
                    SLT:       aluop = ALU_SLT;
                    SLTU:      aluop = ALU_SLTU;
                    SLL: begin
                        aluop   = ALU_SLL;
                        alu_src = 2'd2;
                    end
                    SRL: begin
                        aluop   = ALU_SRL;
                        alu_src = 2'd2;
                    end
                    JR: begin
                        jump_reg = 1'b1;
                        reg_wr   = 1'b0;
                    end
                    default: begin
                        illegal = 1'b1;
                        reg_wr  = 1'b0;
                    end
                endcase
            end
            ADDI, ADDIU: begin
                alu_src = 2'd1;
                ext_op  = 1'b1;
                reg_wr  = 1'b1;
            end
            SLTI, SLTIU: begin
                aluop   = (cuif.opcode == SLTI) ? ALU_SLT : ALU_SLTU;
                alu_src = 2'd1;
                ext_op  = 1'b1;
                reg_wr  = 1'b1;
            end
            ANDI, ORI, XORI: begin
                aluop   = (cuif.opcode == ANDI) ? ALU_AND :
                          (cuif.opcode == ORI)  ? ALU_OR  : ALU_XOR;
                alu_src = 2'd1;
                reg_wr  = 1'b1;
            end
            LUI: begin
                mem_to_reg = 2'd3;
                reg_wr     = 1'b1;
            end
            LW: begin
                alu_src    = 2'd1;
                ext_op     = 1'b1;
                d_ren      = 1'b1;
                mem_to_reg = 2'd1;
                reg_wr     = 1'b1;
            end
            SW: begin
                alu_src = 2'd1;
                ext_op  = 1'b1;
                d_wen   = 1'b1;
            end
            BEQ, BNE: begin
                aluop     = ALU_SUB;
                branch    = 1'b1;
                ext_op    = 1'b1;
                branch_ne = (cuif.opcode == BNE);
            end
            J: begin
                jump = 1'b1;
            end
            JAL: begin
                jump       = 1'b1;
                reg_wr     = 1'b1;
                reg_dst    = 2'd2;
                mem_to_reg = 2'd2;
            end
            HALT: begin
                // Stops the machine through the halt flop; no datapath activity.
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Halt is sticky: once a HALT opcode is seen it holds until reset.
    always_comb begin
        halt_d = halt_q | (cuif.opcode == HALT);
    end

    // Halt register; reset wins over a simultaneous HALT opcode.
    always_ff @(posedge cuif.CLK) begin
        if (cuif.RST) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    assign cuif.aluop    = aluop;
    assign cuif.RegDst   = reg_dst;
    assign cuif.ALUSrc   = alu_src;
    assign cuif.MemtoReg = mem_to_reg;
    assign cuif.RegWr    = reg_wr;
    assign cuif.dREN     = d_ren;
    assign cuif.dWEN     = d_wen;
    assign cuif.ExtOp    = ext_op;
    assign cuif.Branch   = branch;
    assign cuif.BranchNE = branch_ne;
    assign cuif.Jump     = jump;
    assign cuif.JumpReg  = jump_reg;
    assign cuif.illegal  = illegal;
    assign cuif.halt     = halt_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven reference decoder with a scoreboard queue.
// Latency: expectations are pushed just after each rising edge and checked on the falling edge.
// Backpressure: none; one decode is checked per cycle.
module tb_control_unit;
    import cpu_types_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    control_unit_if cuif (.CLK(clk), .RST(rst));
    control_unit dut (.cuif(cuif));

    typedef struct packed {
        logic [3:0] aluop;
        logic [1:0] regdst;
        logic [1:0] alusrc;
        logic [1:0] memtoreg;
        logic       regwr;
        logic       dren;
        logic       dwen;
        logic       extop;
        logic       branch;
        logic       branchne;
        logic       jump;
        logic       jumpreg;
        logic       halt;
        logic       illegal;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        ctl_t       exp;
    } item_t;

    item_t sb[$];
    ctl_t  op_tab[logic [5:0]];
    ctl_t  rt_tab[logic [5:0]];
    logic [5:0] legal_ops[$];
    logic [5:0] legal_fns[$];

    int tests = 0;
    int fails = 0;

    logic [5:0] cur_op;
    logic       cur_rst;
    logic       model_halt;

    function automatic ctl_t mk(input aluop_t a, input int rd, input int as, input int mr,
                                input bit wr, input bit ren, input bit wen, input bit ext,
                                input bit br, input bit bne, input bit j, input bit jr);
        ctl_t c;
        c          = '0;
        c.aluop    = a;
        c.regdst   = 2'(rd);
        c.alusrc   = 2'(as);
        c.memtoreg = 2'(mr);
        c.regwr    = wr;
        c.dren     = ren;
        c.dwen     = wen;
        c.extop    = ext;
        c.branch   = br;
        c.branchne = bne;
        c.jump     = j;
        c.jumpreg  = jr;
        return c;
    endfunction

    // Reference decode: table lookup; anything not in a table is illegal.
    function automatic ctl_t ref_decode(input logic [5:0] op, input logic [5:0] fn);
        ctl_t c;
        if (op == RTYPE) begin
            if (rt_tab.exists(fn)) begin
                c = rt_tab[fn];
            end else begin
                c         = mk(ALU_ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                c.illegal = 1'b1;
            end
        end else if (op_tab.exists(op)) begin
            c = op_tab[op];
        end else begin
            c         = mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            c.illegal = 1'b1;
        end
        return c;
    endfunction

    task automatic build_tables();
        //                     aluop    rd as mr wr rn wn ex br bn j  jr
        rt_tab[ADD]  = mk(ALU_ADD,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        rt_tab[ADDU] = mk(ALU_ADD,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        rt_tab[SUB]  = mk(ALU_SUB,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        rt_tab[SUBU] = mk(ALU_SUB,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        rt_tab[AND]  = mk(ALU_AND,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        rt_tab[OR]   = mk(ALU_OR,   1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        rt_tab[XOR]  = mk(ALU_XOR,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        rt_tab[NOR]  = mk(ALU_NOR,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        rt_tab[SLT]  = mk(ALU_SLT,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        rt_tab[SLTU] = mk(ALU_SLTU, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        rt_tab[SLL]  = mk(ALU_SLL,  1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        rt_tab[SRL]  = mk(ALU_SRL,  1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        rt_tab[JR]   = mk(ALU_ADD,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        op_tab[ADDI]  = mk(ALU_ADD,  0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        op_tab[ADDIU] = mk(ALU_ADD,  0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        op_tab[SLTI]  = mk(ALU_SLT,  0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        op_tab[SLTIU] = mk(ALU_SLTU, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        op_tab[ANDI]  = mk(ALU_AND,  0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        op_tab[ORI]   = mk(ALU_OR,   0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        op_tab[XORI]  = mk(ALU_XOR,  0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        op_tab[LUI]   = mk(ALU_ADD,  0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        op_tab[LW]    = mk(ALU_ADD,  0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        op_tab[SW]    = mk(ALU_ADD,  0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        op_tab[BEQ]   = mk(ALU_SUB,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        op_tab[BNE]   = mk(ALU_SUB,  0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        op_tab[J]     = mk(ALU_ADD,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        op_tab[JAL]   = mk(ALU_ADD,  2, 0, 2, 1, 0, 0, 0, 0, 0, 1, 0);
        op_tab[HALT]  = mk(ALU_ADD,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        legal_ops = '{RTYPE, RTYPE, RTYPE, J, JAL, BEQ, BNE, ADDI, ADDIU, SLTI, SLTIU,
                      ANDI, ORI, XORI, LUI, LW, SW, HALT};
        legal_fns = '{SLL, SRL, JR, ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU};
    endtask

    // One cycle of stimulus: account for the edge just taken, apply new inputs, queue expectation.
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic r);
        item_t it;
        @(posedge clk);
        #1;
        if (cur_rst) begin
            model_halt = 1'b0;
        end else if (cur_op == HALT) begin
            model_halt = 1'b1;
        end
        cuif.opcode = opcode_t'(op);
        cuif.funct  = funct_t'(fn);
        rst         = r;
        cur_op      = op;
        cur_rst     = r;
        it.op       = op;
        it.fn       = fn;
        it.exp      = ref_decode(op, fn);
        it.exp.halt = model_halt;
        sb.push_back(it);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation.
    initial begin
        item_t it;
        ctl_t  act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                it  = sb.pop_front();
                act = {cuif.aluop, cuif.RegDst, cuif.ALUSrc, cuif.MemtoReg, cuif.RegWr,
                       cuif.dREN, cuif.dWEN, cuif.ExtOp, cuif.Branch, cuif.BranchNE,
                       cuif.Jump, cuif.JumpReg, cuif.halt, cuif.illegal};
                tests++;
                if (act !== it.exp) begin
                    fails++;
                    $display("FAIL decode op=%b fn=%b actual=%b required=%b", it.op, it.fn, act, it.exp);
                end
                tests++;
                if ((cuif.dREN && cuif.dWEN) || (cuif.RegWr && cuif.dWEN)) begin
                    fails++;
                    $display("FAIL exclusive op=%b fn=%b actual dREN=%b dWEN=%b RegWr=%b required no overlap",
                             it.op, it.fn, cuif.dREN, cuif.dWEN, cuif.RegWr);
                end
            end
        end
    end

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        logic       r;
        build_tables();
        rst         = 1'b1;
        cuif.opcode = RTYPE;
        cuif.funct  = ADD;
        cur_op      = RTYPE;
        cur_rst     = 1'b1;
        model_halt  = 1'b0;

        // Directed: reset state, key decodes, halt stickiness and reset priority, illegal cases.
        step(RTYPE, ADD, 1'b1);
        step(RTYPE, SLL, 1'b0);
        step(RTYPE, SLT, 1'b0);
        step(RTYPE, XOR, 1'b0);
        step(BEQ, ADD, 1'b0);
        step(LUI, ADD, 1'b0);
        step(SW, ADD, 1'b0);
        step(HALT, ADD, 1'b0);
        step(ORI, ADD, 1'b0);
        step(ORI, ADD, 1'b1);
        step(ORI, ADD, 1'b0);
        step(HALT, ADD, 1'b1);
        step(BNE, ADD, 1'b0);
        step(6'b010000, ADD, 1'b0);
        step(RTYPE, 6'b111111, 1'b0);
        step(RTYPE, JR, 1'b0);
        step(JAL, ADD, 1'b0);
        step(LW, ADD, 1'b1);

        // Randomized: mostly legal encodings with occasional junk and resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            else op = legal_ops[$urandom_range(0, legal_ops.size() - 1)];
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
            else fn = legal_fns[$urandom_range(0, legal_fns.size() - 1)];
            r = ($urandom_range(0, 9) == 0);
            step(op, fn, r);
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            fails++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
